riscv_data_mem_responder: RTL and testbench

//  Word-organised data memory that answers the CPU core's data-memory port (we/addr/wdata/wstrb/rdata).

---
 rtl/riscv_data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_riscv_data_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem_responder.sv
// Word-organised data memory shared by the CPU data port and a host debug port.
// Optional MMIO GPIO register at the all-ones word address when MMIO_GPIO_EN is defined.
module riscv_data_mem_responder #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 15,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_we,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [31:0]       host_req_wdata,
    input  logic [3:0]        host_req_wstrb,
    output logic              host_rsp_valid,
    input  logic              host_rsp_ready,
    output logic [31:0]       host_rsp_rdata,
    output logic [7:0]        gpio_out,
    output logic              dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [7:0]       gpio_q;

    logic [31:0]       mem [DEPTH];

    logic              cpu_act;
    logic              force_slot;
    logic              host_acc;
    logic              cpu_go;

    logic              port_en;
    logic              port_we;
    logic [ADDR_W-1:0] port_addr;
    logic [31:0]       port_wdata;
    logic [3:0]        port_wstrb;
    logic [IDX_W-1:0]  port_idx;
    logic              in_range;
    logic              is_gpio;
    logic              ram_hit;
    logic [31:0]       rd_word;

    // Host handshakes: a request transfers on the edge where host_req_valid && host_req_ready;
    // a response transfers on the edge where host_rsp_valid && host_rsp_ready. Valid must hold until then.
    assign cpu_act        = cpu_re | cpu_we;
    assign force_slot     = (starve_q == CNT_W'(STARVE_LIMIT));
    assign host_req_ready = (state_q == IDLE) && (!cpu_act || force_slot);
    assign host_acc       = host_req_valid && host_req_ready;
    assign cpu_stall      = host_acc && cpu_act;
    assign cpu_go         = cpu_act && !cpu_stall;

    // One access per cycle to the single RAM port: the host when accepted, otherwise the CPU.
    always_comb begin
        port_addr  = cpu_addr;
        port_we    = cpu_we;
        port_wdata = cpu_wdata;
        port_wstrb = cpu_wstrb;
        if (host_acc) begin
            port_addr  = host_req_addr;
            port_we    = host_req_we;
            port_wdata = host_req_wdata;
            port_wstrb = host_req_wstrb;
        end
    end

    assign port_en  = rst_n && (host_acc || cpu_go);
    assign port_idx = port_addr[IDX_W-1:0];
    assign in_range = ({1'b0, port_addr} < DEPTH_L);

`ifdef MMIO_GPIO_EN
    assign is_gpio = (port_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpio_q <= 8'h00;
        end else if (port_en && port_we && is_gpio && port_wstrb[0]) begin
            gpio_q <= port_wdata[7:0];
        end
    end
`else
    assign is_gpio = 1'b0;
    assign gpio_q  = 8'h00;
`endif

    assign ram_hit = in_range && !is_gpio;

    always_comb begin
        rd_word = 32'h0;
        if (is_gpio) begin
            rd_word = {24'h0, gpio_q};
        end else if (in_range) begin
            rd_word = mem[port_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (port_en && port_we && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (port_wstrb[b]) begin
                    mem[port_idx][8*b +: 8] <= port_wdata[8*b +: 8];
                end
            end
        end
    end

    // rd_word is sampled before the write lands, giving read-before-write on a combined access.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (host_acc) begin
                    state_d     = RSP;
                    starve_d    = '0;
                    rsp_rdata_d = host_req_we ? 32'h0 : rd_word;
                end else if (host_req_valid && cpu_act && !force_slot) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            RSP: begin
                if (host_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cpu_go && cpu_re) begin
            cpu_rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            cpu_rdata_q <= 32'h0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cpu_rdata      = cpu_rdata_q;
    assign host_rsp_valid = (state_q == RSP);
    assign host_rsp_rdata = rsp_rdata_q;
    assign gpio_out       = gpio_q;
    assign dbg_state      = (state_q == RSP);
    assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Directed plus randomized bench for riscv_data_mem_responder against a transaction-level memory model.
module tb_riscv_data_mem_responder;
    localparam int DEPTH        = 1024;
    localparam int ADDR_W       = 12;
    localparam int STARVE_LIMIT = 15;
`ifdef MMIO_GPIO_EN
    localparam bit GPIO_EN = 1'b1;
`else
    localparam bit GPIO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_re, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              host_req_valid, host_req_ready, host_req_we;
    logic [ADDR_W-1:0] host_req_addr;
    logic [31:0]       host_req_wdata;
    logic [3:0]        host_req_wstrb;
    logic              host_rsp_valid, host_rsp_ready;
    logic [31:0]       host_rsp_rdata;
    logic [7:0]        gpio_out;
    logic              dbg_state;
    logic [3:0]        dbg_starve_cnt;

    riscv_data_mem_responder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata), .host_req_wstrb(host_req_wstrb),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_rdata(host_rsp_rdata), .gpio_out(gpio_out),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: memory image, GPIO byte, host wait count, outstanding response.
    logic [31:0] m_mem [DEPTH];
    logic [7:0]  m_gpio;
    int          m_wait;
    bit          m_busy;
    logic [31:0] m_rsp;
    logic [31:0] m_cpu_rdata;
    bit          m_accepted;
    logic        obs_ready, obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        if (GPIO_EN && a == 12'hFFF) return {24'h0, m_gpio};
        if (int'(a) >= DEPTH) return 32'h0;
        return m_mem[int'(a)];
    endfunction

    function automatic void m_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                    input logic [3:0] s);
        if (GPIO_EN && a == 12'hFFF) begin
            if (s[0]) m_gpio = d[7:0];
        end else if (int'(a) < DEPTH) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_mem[int'(a)][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic void m_reset();
        m_busy = 0; m_wait = 0; m_rsp = 32'h0; m_cpu_rdata = 32'h0; m_gpio = 8'h0; m_accepted = 0;
    endfunction

    function automatic void m_edge(input bit er, input bit es);
        logic [31:0] rd;
        bit was_busy;
        bit cpu_act;
        if (!rst_n) begin
            m_reset();
            return;
        end
        cpu_act    = cpu_re || cpu_we;
        was_busy   = m_busy;
        m_accepted = er && host_req_valid;
        if (m_accepted) begin
            rd = m_read(host_req_addr);
            if (host_req_we) m_write(host_req_addr, host_req_wdata, host_req_wstrb);
            m_rsp  = host_req_we ? 32'h0 : rd;
            m_busy = 1;
            m_wait = 0;
        end else if (!was_busy && host_req_valid && cpu_act && m_wait < STARVE_LIMIT) begin
            m_wait++;
        end
        if (cpu_act && !es) begin
            rd = m_read(cpu_addr);
            if (cpu_we) m_write(cpu_addr, cpu_wdata, cpu_wstrb);
            if (cpu_re) m_cpu_rdata = rd;
        end
        if (was_busy && host_rsp_ready) m_busy = 0;
    endfunction

    // One clock: check combinational grant at negedge, registered state after the edge.
    task automatic tick();
        bit er, es;
        @(negedge clk);
        er = !m_busy && (!(cpu_re || cpu_we) || m_wait == STARVE_LIMIT);
        es = er && host_req_valid && (cpu_re || cpu_we);
        obs_ready = host_req_ready;
        obs_stall = cpu_stall;
        chk("host_req_ready", 32'(host_req_ready), 32'(er));
        chk("cpu_stall", 32'(cpu_stall), 32'(es));
        @(posedge clk);
        #1;
        m_edge(er, es);
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("host_rsp_valid", 32'(host_rsp_valid), 32'(m_busy));
        chk("host_rsp_rdata", host_rsp_rdata, m_rsp);
        chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
        chk("starve_cnt", 32'(dbg_starve_cnt), 32'(m_wait));
    endtask

    task automatic cpu_idle();
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    endtask

    task automatic cpu_drive(input bit re, input bit we, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    endtask

    task automatic host_drive(input bit v, input bit we, input logic [ADDR_W-1:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        host_req_valid = v; host_req_we = we; host_req_addr = a;
        host_req_wdata = d; host_req_wstrb = s;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 8) return 12'd2000;
        if (r == 9) return 12'hFFF;
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted_at;
        int stall_cnt;
        rst_n = 0;
        cpu_idle();
        host_drive(0, 0, '0, '0, '0);
        host_rsp_ready = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_rsp_valid", 32'(host_rsp_valid), 32'h0);
        chk("rst_rsp_rdata", host_rsp_rdata, 32'h0);
        chk("rst_gpio", 32'(gpio_out), 32'h0);
        chk("rst_starve", 32'(dbg_starve_cnt), 32'h0);
        rst_n = 1;

        for (int a = 0; a < 16; a++) begin
            cpu_drive(0, 1, ADDR_W'(a), $urandom, 4'hF);
            tick();
        end

        // Full-word write then readback.
        cpu_drive(0, 1, 12'd5, 32'hDEADBEEF, 4'hF); tick();
        cpu_drive(1, 0, 12'd5, 32'h0, 4'h0);        tick();
        chk("t1_readback", cpu_rdata, 32'hDEADBEEF);

        // Byte-0 strobe merge.
        cpu_drive(0, 1, 12'd5, 32'h000000AA, 4'b0001); tick();
        cpu_drive(1, 0, 12'd5, 32'h0, 4'h0);           tick();
        chk("t2_merge", cpu_rdata, 32'hDEADBEAA);
        cpu_idle();

        // Host read with CPU idle, response held under backpressure.
        host_drive(1, 0, 12'd5, 32'h0, 4'h0);
        tick();
        chk("t3_accept_ready", 32'(obs_ready), 32'h1);
        host_drive(0, 0, '0, '0, '0);
        chk("t3_rsp_valid", 32'(host_rsp_valid), 32'h1);
        chk("t3_rsp_data", host_rsp_rdata, 32'hDEADBEAA);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_data", host_rsp_rdata, 32'hDEADBEAA);
            chk("t3_hold_ready", 32'(obs_ready), 32'h0);
        end
        host_rsp_ready = 1; tick(); host_rsp_ready = 0;
        chk("t3_rsp_drop", 32'(host_rsp_valid), 32'h0);

        // Starvation: CPU reads every cycle while the host waits.
        accepted_at = 0;
        stall_cnt   = 0;
        host_drive(1, 0, 12'd3, 32'h0, 4'h0);
        for (int c = 1; c <= 40; c++) begin
            cpu_drive(1, 0, ADDR_W'($urandom_range(0, 15)), 32'h0, 4'h0);
            tick();
            if (obs_stall) stall_cnt++;
            if (m_accepted) begin
                accepted_at = c;
                break;
            end
        end
        chk("t4_accept_cycle", 32'(accepted_at), 32'd16);
        chk("t4_stall_count", 32'(stall_cnt), 32'd1);
        chk("t4_starve_clear", 32'(dbg_starve_cnt), 32'h0);
        host_drive(0, 0, '0, '0, '0);
        cpu_idle();
        host_rsp_ready = 1; tick(); host_rsp_ready = 0;

        // Out-of-range write ack and read-as-zero on both ports.
        host_drive(1, 1, 12'd2000, 32'h12345678, 4'hF); tick();
        host_drive(0, 0, '0, '0, '0);
        chk("t5_wr_ack_valid", 32'(host_rsp_valid), 32'h1);
        chk("t5_wr_ack_data", host_rsp_rdata, 32'h0);
        host_rsp_ready = 1; tick(); host_rsp_ready = 0;
        host_drive(1, 0, 12'd2000, 32'h0, 4'h0); tick();
        host_drive(0, 0, '0, '0, '0);
        chk("t5_rd_data", host_rsp_rdata, 32'h0);
        host_rsp_ready = 1; tick(); host_rsp_ready = 0;
        cpu_drive(1, 0, 12'd5, 32'h0, 4'h0);    tick();
        cpu_drive(1, 0, 12'd2000, 32'h0, 4'h0); tick();
        chk("t5_cpu_oor", cpu_rdata, 32'h0);
        cpu_idle();

`ifdef MMIO_GPIO_EN
        cpu_drive(0, 1, 12'hFFF, 32'h0000005A, 4'h1); tick();
        cpu_idle();
        chk("t6_gpio", 32'(gpio_out), 32'h5A);
        host_drive(1, 0, 12'hFFF, 32'h0, 4'h0); tick();
        host_drive(0, 0, '0, '0, '0);
        chk("t6_host_gpio", host_rsp_rdata, 32'h5A);
        rst_n = 0; tick(); rst_n = 1;
        chk("t6_rst_gpio", 32'(gpio_out), 32'h0);
        chk("t6_rst_rsp", 32'(host_rsp_valid), 32'h0);
`else
        cpu_drive(0, 1, 12'hFFF, 32'h0000005A, 4'h1); tick();
        cpu_drive(1, 0, 12'hFFF, 32'h0, 4'h0);        tick();
        cpu_idle();
        chk("t6_gpio_tied", 32'(gpio_out), 32'h0);
        chk("t6_fff_oor", cpu_rdata, 32'h0);
`endif

        // Random traffic: light then heavy CPU load.
        for (int i = 0; i < 400; i++) begin
            if (!host_req_valid || m_accepted) begin
                host_drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(),
                           $urandom, 4'($urandom_range(0, 15)));
            end
            host_rsp_ready = ($urandom_range(0, 2) != 0);
            if ((i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) != 0)) begin
                cpu_drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(),
                          $urandom, 4'($urandom_range(0, 15)));
                if (!cpu_re && !cpu_we) cpu_re = 1;
            end else begin
                cpu_idle();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
